// File: rtl/bbox_pkg.sv
// Shared types and default parameters for the bounding-box tracker.
// Optional smoothing is enabled by defining BBOX_TRACKER_SMOOTH_EN.
package bbox_pkg;

  localparam int COORD_W_DEF     = 13;
  localparam int H_RES_DEF       = 640;
  localparam int V_RES_DEF       = 480;
  localparam int MIN_SIZE_DEF    = 4;
  localparam int ACQ_FRAMES_DEF  = 2;
  localparam int LOST_FRAMES_DEF = 8;
  localparam int ALPHA_SHIFT_DEF = 2;
  localparam int CNT_W           = 16;

  typedef logic [COORD_W_DEF-1:0] coord_t;
  typedef logic [CNT_W-1:0]       cnt_t;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    COAST  = 2'd2
  } trk_state_t;

endpackage

// File: rtl/bbox_iir.sv
// One output channel: clear, load raw, or update (first-order IIR when
// BBOX_TRACKER_SMOOTH_EN is defined, otherwise a straight load of raw).
module bbox_iir
  import bbox_pkg::*;
#(
  parameter int W           = COORD_W_DEF,
  parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         load,
  input  logic         upd,
  input  logic [W-1:0] raw,
  output logic [W-1:0] out
);

`ifdef BBOX_TRACKER_SMOOTH_EN
  localparam bit SMOOTH_EN = 1'b1;
`else
  localparam bit SMOOTH_EN = 1'b0;
`endif

  logic signed [W+1:0] diff;
  logic signed [W+1:0] step;
  logic signed [W+1:0] blend;
  logic                unused_bits;

  // Two guard bits keep the signed difference exact; the blend always
  // lands between out and raw, so the top bits are never needed.
  always_comb begin
    diff  = $signed({2'b00, raw}) - $signed({2'b00, out});
    step  = diff >>> ALPHA_SHIFT;
    blend = $signed({2'b00, out}) + step;
  end

  assign unused_bits = ^blend[W+1:W];

  // NOTE: reset is synchronous -- rstn is sampled only on the clk edge,
  // so it does not appear in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      out <= '0;
    end else if (load || (upd && !SMOOTH_EN)) begin
      out <= raw;
    end else if (upd) begin
      out <= blend[W-1:0];
    end
  end

endmodule

// File: rtl/bbox_tracker.sv
// Frame-rate bounding-box tracker: captures the box on the vsync falling
// edge, qualifies it, and runs a SEARCH/TRACK/COAST lock FSM.
// Define BBOX_TRACKER_SMOOTH_EN to smooth the outputs with a 1/2^ALPHA_SHIFT IIR.
module bbox_tracker
  import bbox_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int MIN_SIZE    = MIN_SIZE_DEF,
  parameter int ACQ_FRAMES  = ACQ_FRAMES_DEF,
  parameter int LOST_FRAMES = LOST_FRAMES_DEF,
  parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               vs_ni,
  input  logic [COORD_W-1:0] T,
  input  logic [COORD_W-1:0] B,
  input  logic [COORD_W-1:0] L,
  input  logic [COORD_W-1:0] R,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic [COORD_W-1:0] width,
  output logic [COORD_W-1:0] height,
  output logic               frame_valid,
  output logic               tracking,
  output logic               lost
);

  typedef logic [COORD_W:0] ext_t;

  localparam ext_t H_LIM   = ext_t'(H_RES);
  localparam ext_t V_LIM   = ext_t'(V_RES);
  localparam ext_t MIN_LIM = ext_t'(MIN_SIZE);
  localparam ext_t ONE     = ext_t'(1);
  localparam cnt_t ACQ_N   = cnt_t'(ACQ_FRAMES);
  localparam cnt_t LOST_N  = cnt_t'(LOST_FRAMES);

  // Frame-edge detect and capture stage (cycle E -> E+1).
  logic               vs_q;
  logic               fr_edge;
  logic               pend;
  logic [COORD_W-1:0] t_q, b_q, l_q, r_q;

  assign fr_edge = vs_q & ~vs_ni;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs_q <= 1'b1;
      pend <= 1'b0;
      t_q  <= '0;
      b_q  <= '0;
      l_q  <= '0;
      r_q  <= '0;
    end else begin
      vs_q <= vs_ni;
      pend <= fr_edge;
      if (fr_edge) begin
        t_q <= T;
        b_q <= B;
        l_q <= L;
        r_q <= R;
      end
    end
  end

  // Qualification and raw geometry at COORD_W+1 bits (cycle E+1).
  ext_t               t_e, b_e, l_e, r_e;
  ext_t               sum_x, sum_y, w_e, h_e;
  logic               frame_ok;
  logic [COORD_W-1:0] raw_cx, raw_cy, raw_w, raw_h;
  logic               unused_bits;

  always_comb begin
    t_e   = {1'b0, t_q};
    b_e   = {1'b0, b_q};
    l_e   = {1'b0, l_q};
    r_e   = {1'b0, r_q};
    sum_x = l_e + r_e;
    sum_y = t_e + b_e;
    w_e   = r_e - l_e + ONE;
    h_e   = b_e - t_e + ONE;
    frame_ok = (b_e >= t_e) && (r_e >= l_e) &&
               (w_e >= MIN_LIM) && (h_e >= MIN_LIM) &&
               (r_e < H_LIM) && (b_e < V_LIM);
  end

  assign raw_cx      = sum_x[COORD_W:1];
  assign raw_cy      = sum_y[COORD_W:1];
  assign raw_w       = w_e[COORD_W-1:0];
  assign raw_h       = h_e[COORD_W-1:0];
  assign unused_bits = ^{sum_x[0], sum_y[0], w_e[COORD_W], h_e[COORD_W]};

  // Lock FSM: next-state decode, then one registered update at E+1 -> E+2.
  trk_state_t state, state_d;
  cnt_t       acq_cnt, acq_d;
  cnt_t       miss_cnt, miss_d;
  logic       do_load, do_upd, do_clr, fv_d, lost_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    acq_d   = acq_cnt;
    miss_d  = miss_cnt;
    do_load = 1'b0;
    do_upd  = 1'b0;
    do_clr  = 1'b0;
    fv_d    = 1'b0;
    lost_d  = 1'b0;
    if (pend) begin
      unique case (state)
        SEARCH: begin
          if (!frame_ok) begin
            acq_d = '0;
          end else if (acq_cnt + cnt_t'(1) >= ACQ_N) begin
            state_d = TRACK;
            acq_d   = '0;
            do_load = 1'b1;
            fv_d    = 1'b1;
          end else begin
            acq_d = acq_cnt + cnt_t'(1);
          end
        end
        TRACK: begin
          fv_d = 1'b1;
          if (frame_ok) begin
            do_upd = 1'b1;
          end else begin
            state_d = COAST;
            miss_d  = cnt_t'(1);
          end
        end
        COAST: begin
          fv_d = 1'b1;
          if (frame_ok) begin
            state_d = TRACK;
            miss_d  = '0;
            do_upd  = 1'b1;
          end else if (miss_cnt + cnt_t'(1) >= LOST_N) begin
            state_d = SEARCH;
            miss_d  = '0;
            lost_d  = 1'b1;
            do_clr  = 1'b1;
          end else begin
            miss_d = miss_cnt + cnt_t'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= SEARCH;
      acq_cnt     <= '0;
      miss_cnt    <= '0;
      frame_valid <= 1'b0;
      lost        <= 1'b0;
      tracking    <= 1'b0;
    end else begin
      state       <= state_d;
      acq_cnt     <= acq_d;
      miss_cnt    <= miss_d;
      frame_valid <= fv_d;
      lost        <= lost_d;
      tracking    <= (state_d != SEARCH);
    end
  end

  bbox_iir #(.W(COORD_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_iir_cx (
    .clk(clk), .rstn(rstn), .clr(do_clr), .load(do_load), .upd(do_upd),
    .raw(raw_cx), .out(center_x)
  );

  bbox_iir #(.W(COORD_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_iir_cy (
    .clk(clk), .rstn(rstn), .clr(do_clr), .load(do_load), .upd(do_upd),
    .raw(raw_cy), .out(center_y)
  );

  bbox_iir #(.W(COORD_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_iir_w (
    .clk(clk), .rstn(rstn), .clr(do_clr), .load(do_load), .upd(do_upd),
    .raw(raw_w), .out(width)
  );

  bbox_iir #(.W(COORD_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_iir_h (
    .clk(clk), .rstn(rstn), .clr(do_clr), .load(do_load), .upd(do_upd),
    .raw(raw_h), .out(height)
  );

endmodule

// File: tb/tb_bbox_tracker.sv
// Self-checking bench for bbox_tracker: directed scenarios plus random
// frames compared against a frame-level behavioural model.
module tb_bbox_tracker;
  import bbox_pkg::*;

  localparam int HR   = 640;
  localparam int VR   = 480;
  localparam int MINS = 4;
  localparam int ACQ  = 2;
  localparam int LOSN = 8;
  localparam int ASH  = 2;

  logic   clk = 1'b0;
  logic   rstn = 1'b0;
  logic   vs_ni = 1'b1;
  coord_t t = '0, b = '0, l = '0, r = '0;
  coord_t center_x, center_y, width, height;
  logic   frame_valid, tracking, lost;

  int checks = 0;
  int errors = 0;

  bbox_tracker #(
    .COORD_W(13), .H_RES(HR), .V_RES(VR), .MIN_SIZE(MINS),
    .ACQ_FRAMES(ACQ), .LOST_FRAMES(LOSN), .ALPHA_SHIFT(ASH)
  ) dut (
    .clk(clk), .rstn(rstn), .vs_ni(vs_ni),
    .T(t), .B(b), .L(l), .R(r),
    .center_x(center_x), .center_y(center_y),
    .width(width), .height(height),
    .frame_valid(frame_valid), .tracking(tracking), .lost(lost)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame-level reference: 0 = searching, 1 = locked, 2 = coasting.
  int m_mode, m_acq, m_miss, m_cx, m_cy, m_w, m_h;

  function automatic int blend(input int o, input int raw);
`ifdef BBOX_TRACKER_SMOOTH_EN
    return o + ((raw - o) >>> ASH);
`else
    return raw;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_acq = 0; m_miss = 0;
    m_cx = 0; m_cy = 0; m_w = 0; m_h = 0;
  endtask

  task automatic model_frame(input int tt, bb, ll, rr, output bit fv, output bit lo);
    bit ok;
    int rcx, rcy, rw, rh;
    ok  = (bb >= tt) && (rr >= ll) && (rr - ll + 1 >= MINS) &&
          (bb - tt + 1 >= MINS) && (rr < HR) && (bb < VR);
    rcx = (ll + rr) / 2;
    rcy = (tt + bb) / 2;
    rw  = rr - ll + 1;
    rh  = bb - tt + 1;
    fv = 1'b0;
    lo = 1'b0;
    if (m_mode == 0) begin
      if (!ok) m_acq = 0;
      else begin
        m_acq++;
        if (m_acq == ACQ) begin
          m_mode = 1; m_acq = 0; fv = 1'b1;
          m_cx = rcx; m_cy = rcy; m_w = rw; m_h = rh;
        end
      end
    end else begin
      fv = 1'b1;
      if (ok) begin
        m_mode = 1; m_miss = 0;
        m_cx = blend(m_cx, rcx); m_cy = blend(m_cy, rcy);
        m_w  = blend(m_w, rw);   m_h  = blend(m_h, rh);
      end else if (m_mode == 1) begin
        m_mode = 2; m_miss = 1;
      end else begin
        m_miss++;
        if (m_miss == LOSN) begin
          m_mode = 0; m_miss = 0; lo = 1'b1;
          m_cx = 0; m_cy = 0; m_w = 0; m_h = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".cx"}, center_x, m_cx);
    check({tag, ".cy"}, center_y, m_cy);
    check({tag, ".w"}, width, m_w);
    check({tag, ".h"}, height, m_h);
    check({tag, ".tracking"}, tracking, (m_mode != 0));
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    vs_ni = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
  endtask

  // Drives one vsync falling edge with the given box, scrambles the inputs
  // after capture, and checks the E+1, E+2 and E+3 cycles.
  task automatic send_frame(input string tag, input int tt, bb, ll, rr);
    bit efv, elo;
    @(posedge clk);
    #1;
    t = coord_t'(tt); b = coord_t'(bb); l = coord_t'(ll); r = coord_t'(rr);
    vs_ni = 1'b0;
    @(posedge clk);
    #1;
    t = coord_t'($urandom); b = coord_t'($urandom);
    l = coord_t'($urandom); r = coord_t'($urandom);
    model_frame(tt, bb, ll, rr, efv, elo);
    @(negedge clk);
    check({tag, ".fv_e1"}, frame_valid, 0);
    @(negedge clk);
    check({tag, ".fv"}, frame_valid, efv);
    check({tag, ".lost"}, lost, elo);
    check_outputs(tag);
    #1 vs_ni = 1'b1;
    @(negedge clk);
    check({tag, ".fv_e3"}, frame_valid, 0);
    check({tag, ".lost_e3"}, lost, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic rand_box(input int bad_pct, output int tt, bb, ll, rr);
    int sel;
    ll = int'($urandom_range(1, HR - MINS));
    rr = int'($urandom_range(ll + MINS - 1, HR - 1));
    tt = int'($urandom_range(1, VR - MINS));
    bb = int'($urandom_range(tt + MINS - 1, VR - 1));
    if (int'($urandom_range(0, 99)) < bad_pct) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: rr = ll - 1;
        1: rr = ll + MINS - 2;
        2: rr = int'($urandom_range(HR, 8191));
        default: bb = int'($urandom_range(VR, 8191));
      endcase
    end
  endtask

  initial begin
    int tt, bb, ll, rr;
    int exp_cx;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst.fv", frame_valid, 0);
    check("rst.lost", lost, 0);
    check_outputs("rst");

    // Out-of-range and too-narrow boxes clear the acquisition count
    send_frame("acq1", 50, 89, 100, 139);
    send_frame("bad_r640", 50, 89, 100, 640);
    send_frame("acq2", 50, 89, 100, 139);
    send_frame("bad_w3", 50, 89, 100, 102);
    send_frame("acq3", 50, 89, 100, 139);
    check("acq3.not_tracking", tracking, 0);

    // Two valid frames acquire with the known geometry
    do_reset();
    send_frame("lock1", 50, 89, 100, 139);
    send_frame("lock2", 50, 89, 100, 139);
    check("lock2.cx_const", center_x, 119);
    check("lock2.cy_const", center_y, 69);
    check("lock2.w_const", width, 40);
    check("lock2.h_const", height, 40);
    check("lock2.tracking_const", tracking, 1);

    // One R<L frame coasts with held outputs, then seven more drop the target
    send_frame("coast1", 50, 89, 139, 100);
    check("coast1.held_cx", center_x, 119);
    check("coast1.tracking_const", tracking, 1);
    for (int i = 2; i <= LOSN; i++) send_frame($sformatf("coast%0d", i), 50, 89, 139, 100);
    check("lost.tracking_const", tracking, 0);
    check("lost.cx_const", center_x, 0);

    // Re-acquire at cx=100 then move raw cx to 140
    send_frame("mv1", 50, 89, 80, 120);
    send_frame("mv2", 50, 89, 80, 120);
    send_frame("mv3", 50, 89, 120, 160);
`ifdef BBOX_TRACKER_SMOOTH_EN
    exp_cx = 110;
`else
    exp_cx = 140;
`endif
    check("mv3.cx_const", center_x, exp_cx);

    // Reset during E+1 discards the in-flight frame
    @(posedge clk);
    #1;
    t = 50; b = 89; l = 100; r = 139; vs_ni = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst.fv", frame_valid, 0);
    model_reset();
    check_outputs("midrst");
    #1 vs_ni = 1'b1;
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("midrst.idle%0d", i), frame_valid, 0);
    end
    check_outputs("midrst.after");
    send_frame("post_rst", 50, 89, 100, 139);

    // Random frames in alternating quiet and noisy segments
    for (int s = 0; s < 6; s++) begin
      for (int f = 0; f < 25; f++) begin
        rand_box((s % 2 == 0) ? 15 : 75, tt, bb, ll, rr);
        send_frame($sformatf("rnd%0d_%0d", s, f), tt, bb, ll, rr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bbox_tracker.md
BBOX_TRACKER -- requirements
Module: bbox_tracker

Interface
REQ-001 SHALL have parameter COORD_W, default 13, coordinate width matching the row/col counters.
REQ-002 SHALL have parameter H_RES, default 640, active columns.
REQ-003 SHALL have parameter V_RES, default 480, active rows.
REQ-004 SHALL have parameter MIN_SIZE, default 4, minimum box width/height in pixels.
REQ-005 SHALL have parameter ACQ_FRAMES, default 2, consecutive valid frames to acquire.
REQ-006 SHALL have parameter LOST_FRAMES, default 8, consecutive invalid frames to drop the target.
REQ-007 SHALL have parameter ALPHA_SHIFT, default 2, smoothing gain 1/2^ALPHA_SHIFT.
REQ-008 SHALL have port clk, input, 1, rising-edge clock.
REQ-009 SHALL have port rstn, input, 1, reset; synchronous, active-low; clock clk.
REQ-010 SHALL have port vs_ni, input, 1, active-low vsync, aligned with the box inputs.
REQ-011 SHALL have ports T, B, L, R, input, COORD_W each, per-frame bounding box from the box stage.
REQ-012 SHALL have ports center_x, center_y, output, COORD_W each, tracked box centre.
REQ-013 SHALL have ports width, height, output, COORD_W each, tracked box size.
REQ-014 SHALL have port frame_valid, output, 1, one-cycle pulse when outputs update.
REQ-015 SHALL have port tracking, output, 1, high in TRACK and COAST.
REQ-016 SHALL have port lost, output, 1, one-cycle pulse on COAST->SEARCH.

Function
REQ-017 SHALL register vs_ni; frame edge E = cycle where the registered value is 1 and vs_ni is 0.
REQ-018 SHALL capture T/B/L/R in cycle E; later input changes SHALL NOT affect that frame.
REQ-019 Frame SHALL be valid iff B>=T, R>=L, R-L+1>=MIN_SIZE, B-T+1>=MIN_SIZE, R<H_RES, B<V_RES.
REQ-020 Raw values: cx=(L+R)>>1, cy=(T+B)>>1, w=R-L+1, h=B-T+1. Sums SHALL be computed at COORD_W+1 bits with no overflow.
REQ-021 FSM states SHALL be SEARCH, TRACK, COAST; the reset state is SEARCH.
REQ-022 SEARCH: a valid frame SHALL increment acq_cnt; an invalid frame SHALL clear it; reaching ACQ_FRAMES SHALL go to TRACK, load outputs directly, and clear acq_cnt.
REQ-023 TRACK: a valid frame SHALL update outputs; an invalid frame SHALL go to COAST with miss_cnt=1 and hold outputs.
REQ-024 COAST: a valid frame SHALL go to TRACK, clear miss_cnt, and update outputs; an invalid frame SHALL increment miss_cnt.
REQ-025 In COAST, when miss_cnt reaches LOST_FRAMES, the block SHALL go to SEARCH, pulse lost, and zero the outputs.
REQ-026 Outputs and frame_valid SHALL update in cycle E+2 for every frame processed in TRACK or COAST, including held frames. SEARCH SHALL never pulse frame_valid except on the acquiring frame.
REQ-027 A second edge arriving before E+2 is impossible (frame period >> 2); no queuing is required.

Reset
REQ-028 While rstn=0 at a clk edge: state=SEARCH, counters=0, all outputs=0, pulses=0, and the vs_ni register=1 (no false edge on release).
REQ-029 A reset asserted mid-pipeline SHALL discard the in-flight frame; no frame_valid SHALL follow.

Configuration
REQ-030 With BBOX_TRACKER_SMOOTH_EN defined, a TRACK/COAST valid-frame update SHALL be out = out + ((raw - out) >>> ALPHA_SHIFT), signed, COORD_W+2 bits, for all four outputs. The acquiring frame SHALL load raw values.
REQ-031 Without BBOX_TRACKER_SMOOTH_EN, outputs SHALL equal raw values; latency SHALL be unchanged.

Structure
REQ-032 Package bbox_pkg SHALL hold the coord_t typedef, the trk_state_t enum, and default parameter constants.
REQ-033 Sub-module bbox_iir SHALL implement one smoothing channel (load/update/hold) and be instantiated four times.

Verification
REQ-034 Reset then two valid frames L=100,R=139,T=50,B=89 -> second frame E+2: frame_valid=1, tracking=1, center=(119,69), size=(40,40).
REQ-035 In TRACK, one frame with R<L -> state COAST, outputs held at previous values, frame_valid at E+2.
REQ-036 From TRACK, 8 consecutive invalid frames -> lost pulse at the 8th frame's E+2, outputs 0, tracking=0.
REQ-037 SMOOTH_EN with ALPHA_SHIFT=2: tracked cx=100, new raw cx=140 -> center_x=110.
REQ-038 rstn low at E+1 -> no frame_valid; all outputs 0; after release, first vs_ni low level produces no spurious edge.
REQ-039 Box with R=640 (>=H_RES) or width 3 -> treated as invalid; acq_cnt cleared in SEARCH.
